subservient_dbg_host: RTL and testbench



---
 rtl/subservient_dbg_host.sv | 156 +++++++++++++++
 tb/tb_subservient_dbg_host.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/subservient_dbg_host.sv
// Host-side serializer for the bit-serial debug link: shifts one command frame out MSB-first,
// waits a fixed gap, then deserializes a read-back word and strobes it out.
module subservient_dbg_host #(
  parameter int dbg_aw     = 0,
  parameter int gap_cycles = 4,
  parameter int rsp_len    = 32
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst,
  input  logic                                   i_cmd_valid,
  output logic                                   o_cmd_ready,
  input  logic [((dbg_aw > 0) ? dbg_aw : 1)-1:0] i_cmd_id,
  input  logic [3:0]                             i_cmd_sel,
  input  logic [31:0]                            i_cmd_adr,
  input  logic [31:0]                            i_cmd_dat,
  output logic                                   o_dbg_data,
  output logic                                   o_dbg_valid,
  input  logic                                   i_dbg_data,
  output logic                                   o_rsp_valid,
  output logic [31:0]                            o_rsp_rdt,
  output logic                                   o_busy
);

  localparam int FRAME_LEN = dbg_aw + 68;

  localparam logic [15:0] FRAME_LAST = 16'(FRAME_LEN - 1);
  localparam logic [15:0] GAP_LAST   = 16'((gap_cycles > 0) ? gap_cycles - 1 : 0);
  localparam logic [15:0] RESP_LAST  = 16'((rsp_len > 0) ? rsp_len - 1 : 0);

  if (dbg_aw < 0 || rsp_len < 0 || rsp_len > 32 || gap_cycles < 0 ||
      gap_cycles > 65535 || FRAME_LEN > 65535) begin : g_param_check
    $error("subservient_dbg_host: parameter out of range");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    GAP   = 3'd2,
    RESP  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Phase that follows the frame, and the one that follows the gap, with empty phases skipped.
  localparam state_t AFTER_FRAME = (gap_cycles > 0) ? GAP : ((rsp_len > 0) ? RESP : DONE);
  localparam state_t AFTER_GAP   = (rsp_len > 0) ? RESP : DONE;

  state_t                 state;
  logic [15:0]            cnt;
  logic [FRAME_LEN-1:0]   frame;
  logic [FRAME_LEN-2:0]   sr;
  logic [31:0]            cap;
  logic                   dbg_data;
  logic                   dbg_valid;
  logic                   rsp_valid;
  logic [31:0]            rsp_rdt;

  if (dbg_aw > 0) begin : g_id
    assign frame = {i_cmd_id, i_cmd_sel, i_cmd_adr, i_cmd_dat};
  end else begin : g_no_id
    logic unused_id;
    assign unused_id = ^i_cmd_id;
    assign frame     = {i_cmd_sel, i_cmd_adr, i_cmd_dat};
  end

  assign o_cmd_ready = (state == IDLE) && !i_rst;
  assign o_busy      = (state != IDLE);
  assign o_dbg_data  = dbg_data;
  assign o_dbg_valid = dbg_valid;
  assign o_rsp_valid = rsp_valid;
  assign o_rsp_rdt   = rsp_rdt;

  // Remaining frame bits below the one currently on the wire; reloaded freely while idle.
  always_ff @(posedge i_clk) begin
    if (state == IDLE) begin
      sr <= frame[FRAME_LEN-2:0];
    end else if (state == SHIFT) begin
      sr <= {sr[FRAME_LEN-3:0], 1'b0};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cap       <= '0;
      dbg_data  <= 1'b0;
      dbg_valid <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdt   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_cmd_valid) begin
            state     <= SHIFT;
            cnt       <= '0;
            cap       <= '0;
            dbg_data  <= frame[FRAME_LEN-1];
            dbg_valid <= 1'b1;
          end
        end
        SHIFT: begin
          if (cnt == FRAME_LAST) begin
            state     <= AFTER_FRAME;
            cnt       <= '0;
            dbg_data  <= 1'b0;
            dbg_valid <= (AFTER_FRAME == RESP);
            if (AFTER_FRAME == DONE) begin
              rsp_valid <= 1'b1;
              rsp_rdt   <= cap;
            end
          end else begin
            cnt      <= cnt + 16'd1;
            dbg_data <= sr[FRAME_LEN-2];
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            state     <= AFTER_GAP;
            cnt       <= '0;
            dbg_valid <= (AFTER_GAP == RESP);
            if (AFTER_GAP == DONE) begin
              rsp_valid <= 1'b1;
              rsp_rdt   <= cap;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RESP: begin
          // The last read-back bit goes straight into the output word as well as the capture register.
          cap <= {cap[30:0], i_dbg_data};
          if (cnt == RESP_LAST) begin
            state     <= DONE;
            cnt       <= '0;
            dbg_valid <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdt   <= {cap[30:0], i_dbg_data};
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          dbg_data  <= 1'b0;
          dbg_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_subservient_dbg_host.sv
// Bench for subservient_dbg_host: three instances (default, 2-bit id, no gap/no response)
// driven with directed and random commands against a timing/frame reference model.
module tb_subservient_dbg_host;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  cmd_valid;
  logic [1:0]  cmd_id;
  logic [3:0]  cmd_sel;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic        dbg_in;
  logic [2:0]  rdy, dd, dv, rv, busy;
  logic [31:0] rdt0, rdt1, rdt2;
  logic [31:0] last_rdt [3];

  int tests = 0;
  int fails = 0;

  subservient_dbg_host u0 (
    .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid[0]), .o_cmd_ready(rdy[0]),
    .i_cmd_id(cmd_id[0]), .i_cmd_sel(cmd_sel), .i_cmd_adr(cmd_adr), .i_cmd_dat(cmd_dat),
    .o_dbg_data(dd[0]), .o_dbg_valid(dv[0]), .i_dbg_data(dbg_in),
    .o_rsp_valid(rv[0]), .o_rsp_rdt(rdt0), .o_busy(busy[0])
  );

  subservient_dbg_host #(.dbg_aw(2)) u1 (
    .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid[1]), .o_cmd_ready(rdy[1]),
    .i_cmd_id(cmd_id), .i_cmd_sel(cmd_sel), .i_cmd_adr(cmd_adr), .i_cmd_dat(cmd_dat),
    .o_dbg_data(dd[1]), .o_dbg_valid(dv[1]), .i_dbg_data(dbg_in),
    .o_rsp_valid(rv[1]), .o_rsp_rdt(rdt1), .o_busy(busy[1])
  );

  subservient_dbg_host #(.gap_cycles(0), .rsp_len(0)) u2 (
    .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid[2]), .o_cmd_ready(rdy[2]),
    .i_cmd_id(cmd_id[0]), .i_cmd_sel(cmd_sel), .i_cmd_adr(cmd_adr), .i_cmd_dat(cmd_dat),
    .o_dbg_data(dd[2]), .o_dbg_valid(dv[2]), .i_dbg_data(dbg_in),
    .o_rsp_valid(rv[2]), .o_rsp_rdt(rdt2), .o_busy(busy[2])
  );

  function automatic int aw_of(input int d);
    return (d == 1) ? 2 : 0;
  endfunction

  function automatic int gap_of(input int d);
    return (d == 2) ? 0 : 4;
  endfunction

  function automatic int rsp_of(input int d);
    return (d == 2) ? 0 : 32;
  endfunction

  function automatic logic [31:0] rdt_of(input int d);
    case (d)
      0:       return rdt0;
      1:       return rdt1;
      default: return rdt2;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [69:0] got, input logic [69:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full transaction: accept on the first cycle, then watch every cycle up to the expected strobe.
  // The target model answers by counting o_dbg_valid cycles: the first FRAME_LEN are frame bits,
  // the following ones are read-back slots filled MSB-first from rword.
  task automatic txn(input int d, input logic [1:0] id, input logic [3:0] sel,
                     input logic [31:0] adr, input logic [31:0] dat,
                     input logic [31:0] rword, input bit hold);
    int fl, gp, rl, lat, nval, seen, npulse, bad, idx;
    logic [69:0] obs, expf;
    logic [31:0] expr, got_rdt;
    logic        exp_dv;
    fl = aw_of(d) + 68;
    gp = gap_of(d);
    rl = rsp_of(d);
    lat = 1 + fl + gp + rl;
    expf = {2'b00, sel, adr, dat};
    if (aw_of(d) == 2) expf[69:68] = id;
    expr = '0;
    for (int i = 0; i < rl; i++) expr[i] = rword[i];
    nval = 0; seen = -1; npulse = 0; bad = 0; obs = '0; got_rdt = '0;

    @(negedge clk);
    chk($sformatf("u%0d_idle_ready", d), 70'(rdy[d]), 70'(1));
    chk($sformatf("u%0d_rdt_hold", d), 70'(rdt_of(d)), 70'(last_rdt[d]));
    chk($sformatf("u%0d_rsp_idle_low", d), 70'(rv[d]), 70'(0));
    cmd_id = id; cmd_sel = sel; cmd_adr = adr; cmd_dat = dat;
    cmd_valid[d] = 1'b1;
    dbg_in = 1'($urandom);

    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (hold) begin
        cmd_id  = 2'($urandom);
        cmd_sel = 4'($urandom);
        cmd_adr = $urandom;
        cmd_dat = $urandom;
      end else begin
        cmd_valid[d] = 1'b0;
      end
      exp_dv = (c <= fl) || (c > fl + gp && c <= fl + gp + rl);
      if (dv[d] !== exp_dv || busy[d] !== 1'b1 || rdy[d] !== 1'b0) bad++;
      if (dv[d] === 1'b1 && nval < fl) obs = {obs[68:0], dd[d]};
      else if (dd[d] !== 1'b0) bad++;
      idx = rl - 1 - (nval - fl);
      if (dv[d] === 1'b1 && nval >= fl && idx >= 0 && idx < 32) dbg_in = rword[idx];
      else dbg_in = 1'($urandom);
      if (dv[d] === 1'b1) nval++;
      if (rv[d] === 1'b1) begin
        npulse++;
        seen = c;
        got_rdt = rdt_of(d);
      end
    end

    chk($sformatf("u%0d_frame", d), obs, expf);
    chk($sformatf("u%0d_timing", d), 70'(bad), 70'(0));
    chk($sformatf("u%0d_valid_count", d), 70'(nval), 70'(fl + rl));
    chk($sformatf("u%0d_latency", d), 70'(seen), 70'(lat));
    chk($sformatf("u%0d_rsp_pulses", d), 70'(npulse), 70'(1));
    chk($sformatf("u%0d_rsp_rdt", d), 70'(got_rdt), 70'(expr));
    last_rdt[d] = expr;
  endtask

  initial begin
    int cnt;
    rst = 1'b1;
    cmd_valid = '0;
    cmd_id = '0; cmd_sel = '0; cmd_adr = '0; cmd_dat = '0;
    dbg_in = 1'b0;
    for (int i = 0; i < 3; i++) last_rdt[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_dbg_valid", 70'(dv), 70'(0));
    chk("rst_dbg_data", 70'(dd), 70'(0));
    chk("rst_rsp_valid", 70'(rv), 70'(0));
    chk("rst_busy", 70'(busy), 70'(0));
    chk("rst_ready_in_reset", 70'(rdy), 70'(0));
    chk("rst_rdt", 70'({rdt0, rdt1[5:0]} | 38'(rdt2)), 70'(0));
    rst = 1'b0;
    #1;
    chk("rst_ready_after", 70'(rdy), 70'(3'b111));

    // Basic frame with DEAD_BEEF read-back
    txn(0, 2'b00, 4'hF, 32'h4000_0000, 32'hA5A5_5A5A, 32'hDEAD_BEEF, 1'b0);
    // No gap, no response phase
    txn(2, 2'b00, 4'hF, 32'h4000_0000, 32'hA5A5_5A5A, $urandom, 1'b0);
    // Two-bit core id
    txn(1, 2'b10, 4'($urandom), $urandom, $urandom, $urandom, 1'b0);

    // i_cmd_valid held high with fields churning while busy
    txn(0, 2'b00, 4'($urandom), $urandom, $urandom, $urandom, 1'b1);
    txn(0, 2'b00, 4'($urandom), $urandom, $urandom, $urandom, 1'b1);
    txn(0, 2'b00, 4'($urandom), $urandom, $urandom, $urandom, 1'b1);
    @(negedge clk);
    cmd_valid[0] = 1'b0;

    // Reset after 10 frame bits
    @(negedge clk);
    cmd_sel = 4'h3; cmd_adr = $urandom; cmd_dat = $urandom;
    cmd_valid[0] = 1'b1;
    cnt = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      cmd_valid[0] = 1'b0;
      dbg_in = 1'($urandom);
      if (dv[0] === 1'b1) cnt++;
    end
    chk("pre_rst_frame_bits", 70'(cnt), 70'(10));
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_dbg_valid", 70'(dv[0]), 70'(0));
    rst = 1'b0;
    #1;
    chk("midrst_ready", 70'(rdy[0]), 70'(1));
    chk("midrst_busy", 70'(busy[0]), 70'(0));
    cnt = 0;
    repeat (110) begin
      @(negedge clk);
      dbg_in = 1'($urandom);
      if (rv[0] !== 1'b0) cnt++;
    end
    chk("midrst_no_rsp", 70'(cnt), 70'(0));
    for (int i = 0; i < 3; i++) last_rdt[i] = '0;

    // Reset beats a simultaneous accept
    @(negedge clk);
    cmd_valid[0] = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_vs_accept_busy", 70'(busy[0]), 70'(0));
    chk("rst_vs_accept_valid", 70'(dv[0]), 70'(0));
    cmd_valid[0] = 1'b0;
    rst = 1'b0;

    txn(0, 2'b00, 4'($urandom), 32'h0000_0010, $urandom, $urandom, 1'b0);

    // Random commands across all three configurations
    for (int k = 0; k < 6; k++) begin
      txn(k % 3, 2'($urandom), 4'($urandom), $urandom, $urandom, $urandom, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
